// File: rtl/fifo_vc.sv
// fifo_vc: NUM_VC independent circular flit FIFOs, shared write port selected by write_vc, one pop per VC.
// Latency: a write is visible on item_out/flags after the next clk edge; item_out is show-ahead from the head slot.
// Backpressure: writes to a full VC and pops of an empty VC are dropped; full/almost_full/count drive upstream credits.
// Optional: define FIFO_VC_ERR_EN to add sticky overflow/underflow error outputs err_ovf/err_udf.
module fifo_vc #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int NUM_VC     = 4,
    parameter int VC_LOG2    = 2,
    parameter int AF_THRESH  = 12
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             write,
    input  logic [VC_LOG2-1:0]               write_vc,
    input  logic [WIDTH-1:0]                 item_in,
    input  logic [NUM_VC-1:0]                read,
    output logic [NUM_VC*WIDTH-1:0]          item_out,
    output logic [NUM_VC-1:0]                full,
    output logic [NUM_VC-1:0]                empty,
    output logic [NUM_VC-1:0]                almost_full,
    output logic [NUM_VC*(DEPTH_LOG2+1)-1:0] count
`ifdef FIFO_VC_ERR_EN
    ,
    output logic [NUM_VC-1:0]                err_ovf,
    output logic [NUM_VC-1:0]                err_udf
`endif
);

    localparam int D  = 1 << DEPTH_LOG2;
    localparam int CW = DEPTH_LOG2 + 1;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        localparam logic [VC_LOG2-1:0] VC_ID = VC_LOG2'(v);

        logic [WIDTH-1:0]      mem [D];
        logic [DEPTH_LOG2-1:0] wptr;
        logic [DEPTH_LOG2-1:0] rptr;
        logic [CW-1:0]         cnt;
        logic [CW-1:0]         cnt_nxt;
        logic                  full_q;
        logic                  empty_q;
        logic                  af_q;
        logic                  wr_req;
        logic                  do_wr;
        logic                  do_rd;

        // Out-of-range write_vc never matches any VC_ID, so such writes are dropped everywhere.
        assign wr_req = write && (write_vc == VC_ID);
        assign do_wr  = wr_req && !full_q;
        assign do_rd  = read[v] && !empty_q;

        // Next occupancy; a simultaneous accepted push and pop cancel out.
        always_comb begin
            cnt_nxt = cnt;
            if (do_wr && !do_rd) begin
                cnt_nxt = cnt + CW'(1);
            end else if (do_rd && !do_wr) begin
                cnt_nxt = cnt - CW'(1);
            end
        end

        // Storage, pointers, occupancy and flags registered from the next occupancy.
        always_ff @(posedge clk) begin
            if (reset) begin
                wptr    <= '0;
                rptr    <= '0;
                cnt     <= '0;
                full_q  <= 1'b0;
                empty_q <= 1'b1;
                af_q    <= 1'b0;
                for (int i = 0; i < D; i++) begin
                    mem[i] <= '0;
                end
            end else begin
                if (do_wr) begin
                    mem[wptr] <= item_in;
                    wptr      <= wptr + DEPTH_LOG2'(1);
                end
                if (do_rd) begin
                    rptr <= rptr + DEPTH_LOG2'(1);
                end
                cnt     <= cnt_nxt;
                full_q  <= (cnt_nxt == CW'(D));
                empty_q <= (cnt_nxt == '0);
                af_q    <= (cnt_nxt >= CW'(AF_THRESH));
            end
        end

        assign item_out[v*WIDTH +: WIDTH] = mem[rptr];
        assign count[v*CW +: CW]          = cnt;
        assign full[v]                    = full_q;
        assign empty[v]                   = empty_q;
        assign almost_full[v]             = af_q;

`ifdef FIFO_VC_ERR_EN
        logic ovf_q;
        logic udf_q;

        // Sticky error capture of requests dropped for full/empty; only reset clears them.
        always_ff @(posedge clk) begin
            if (reset) begin
                ovf_q <= 1'b0;
                udf_q <= 1'b0;
            end else begin
                if (wr_req && full_q) begin
                    ovf_q <= 1'b1;
                end
                if (read[v] && empty_q) begin
                    udf_q <= 1'b1;
                end
            end
        end

        assign err_ovf[v] = ovf_q;
        assign err_udf[v] = udf_q;
`endif
    end

endmodule
